// File: rtl/lamp_ctrl.sv
// rtl/lamp_ctrl.sv - three-way staircase lamp: synchronise, debounce, parity of switch levels
module lamp_ctrl #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic S1,
    input  logic S2,
    input  logic S3,
    output logic F,
    output logic toggle
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [2:0]       raw;
    logic [2:0]       sy1;
    logic [2:0]       sy2;
    logic [2:0]       deb;
    logic [CNT_W-1:0] cnt [3];
    logic             parity;

    assign raw    = {S3, S2, S1};
    assign parity = ^deb;

    always_ff @(posedge clk) begin
        if (rst) begin
            sy1    <= '0;
            sy2    <= '0;
            deb    <= '0;
            F      <= 1'b0;
            toggle <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sy1 <= raw;
            sy2 <= sy1;
            // A level is accepted only after DEBOUNCE consecutive mismatching edges;
            // any return to the filtered level restarts the count.
            for (int i = 0; i < 3; i++) begin
                if (sy2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sy2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
            F      <= parity;
            toggle <= (parity != F);
        end
    end

endmodule

// File: tb/tb_lamp_ctrl.sv
// tb/tb_lamp_ctrl.sv - directed and randomized checks of lamp_ctrl against a window-based reference model
module tb_lamp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s1 = 1'b0;
    logic s2 = 1'b0;
    logic s3 = 1'b0;
    logic f4, tog4, f1, tog1;

    int checks = 0;
    int errors = 0;

    int edge_n   = 0;
    int tog4_cnt = 0;
    int tog1_cnt = 0;
    int chg4     = 0;
    int chg1     = 0;

    // reference model: index 0 -> DEBOUNCE=4 instance, index 1 -> DEBOUNCE=1 instance
    int         win_len [2] = '{4, 1};
    logic [2:0] m_deb   [2];
    logic       m_f     [2];
    logic       m_tog   [2];
    logic [2:0] pipe0, pipe1;
    logic [2:0] sy2_q [$];

    always #5 clk = ~clk;

    lamp_ctrl #(.DEBOUNCE(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .S1(s1), .S2(s2), .S3(s3), .F(f4), .toggle(tog4)
    );

    lamp_ctrl #(.DEBOUNCE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .S1(s1), .S2(s2), .S3(s3), .F(f1), .toggle(tog1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic [2:0] s, input logic r);
        logic mism;
        if (r) begin
            pipe0 = '0;
            pipe1 = '0;
            sy2_q.delete();
            for (int m = 0; m < 2; m++) begin
                m_deb[m] = '0;
                m_f[m]   = 1'b0;
                m_tog[m] = 1'b0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                m_tog[m] = (^m_deb[m]) != m_f[m];
                m_f[m]   = ^m_deb[m];
            end
            sy2_q.push_back(pipe1);
            if (sy2_q.size() > 4) void'(sy2_q.pop_front());
            // a switch is accepted when its last win_len synchronised samples all disagree with it
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 3; i++) begin
                    if (sy2_q.size() >= win_len[m]) begin
                        mism = 1'b1;
                        for (int k = 0; k < win_len[m]; k++) begin
                            if (sy2_q[sy2_q.size() - 1 - k][i] == m_deb[m][i]) mism = 1'b0;
                        end
                        if (mism) m_deb[m][i] = ~m_deb[m][i];
                    end
                end
            end
            pipe1 = pipe0;
            pipe0 = s;
        end
    endtask

    task automatic step(input logic [2:0] s, input logic r);
        @(negedge clk);
        {s3, s2, s1} = s;
        rst = r;
        @(posedge clk);
        edge_n++;
        model_edge(s, r);
        #1;
        chk("f_d4", f4, m_f[0]);
        chk("tog_d4", tog4, m_tog[0]);
        chk("f_d1", f1, m_f[1]);
        chk("tog_d1", tog1, m_tog[1]);
        if (tog4) begin tog4_cnt++; chg4 = edge_n; end
        if (tog1) begin tog1_cnt++; chg1 = edge_n; end
    endtask

    initial begin
        logic [7:0] tt;
        logic       prev_f;
        int         e0, t4, t1, len;
        logic [2:0] pat;

        tt     = 8'b1001_0110;
        prev_f = 1'b0;

        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 1'b0);
            chk("reset_idle_f", f4, 0);
            chk("reset_idle_tog", tog4, 0);
        end

        for (int p = 0; p < 8; p++) begin
            e0  = edge_n + 1;
            t4  = tog4_cnt;
            t1  = tog1_cnt;
            pat = 3'(p);
            for (int c = 0; c < 50; c++) step(pat, 1'b0);
            chk("walk_f", f4, tt[p]);
            chk("walk_tog_count_d4", tog4_cnt - t4, (tt[p] != prev_f) ? 1 : 0);
            chk("walk_tog_count_d1", tog1_cnt - t1, (tt[p] != prev_f) ? 1 : 0);
            if (tt[p] != prev_f) begin
                chk("walk_latency_d4", chg4 - e0, 6);
                chk("walk_latency_d1", chg1 - e0, 3);
            end
            prev_f = tt[p];
        end

        for (int c = 0; c < 20; c++) step(3'b000, 1'b0);
        t4 = tog4_cnt;
        t1 = tog1_cnt;
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        for (int c = 0; c < 20; c++) step(3'b000, 1'b0);
        chk("glitch_f", f4, 0);
        chk("glitch_tog_d4", tog4_cnt - t4, 0);
        chk("glitch_tog_d1", tog1_cnt - t1, 2);

        t4 = tog4_cnt;
        t1 = tog1_cnt;
        for (int c = 0; c < 20; c++) step(3'b011, 1'b0);
        chk("simul_f", f4, 0);
        chk("simul_tog_d4", tog4_cnt - t4, 0);
        chk("simul_tog_d1", tog1_cnt - t1, 0);
        for (int c = 0; c < 20; c++) step(3'b000, 1'b0);

        step(3'b010, 1'b0);
        step(3'b010, 1'b0);
        step(3'b010, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(3'b010, 1'b1);
            chk("mid_rst_f", f4, 0);
            chk("mid_rst_tog", tog4, 0);
        end
        e0 = edge_n + 1;
        t4 = tog4_cnt;
        for (int c = 0; c < 15; c++) step(3'b010, 1'b0);
        chk("post_rst_f", f4, 1);
        chk("post_rst_tog_count", tog4_cnt - t4, 1);
        chk("post_rst_latency_d4", chg4 - e0, 6);
        chk("post_rst_latency_d1", chg1 - e0, 3);

        e0 = edge_n + 1;
        for (int c = 0; c < 10; c++) step(3'b110, 1'b0);
        chk("s3_latency_d1", chg1 - e0, 3);
        chk("s3_f_d1", f1, 0);
        t4 = tog4_cnt;
        t1 = tog1_cnt;
        step(3'b010, 1'b0);
        for (int c = 0; c < 10; c++) step(3'b110, 1'b0);
        chk("pulse1_tog_d1", tog1_cnt - t1, 2);
        chk("pulse1_tog_d4", tog4_cnt - t4, 0);

        for (int n = 0; n < 70; n++) begin
            pat = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 10);
            if ($urandom_range(0, 24) == 0) begin
                step(pat, 1'b1);
                step(pat, 1'b1);
            end
            for (int c = 0; c < len; c++) step(pat, 1'b0);
        end
        for (int c = 0; c < 12; c++) step(pat, 1'b0);
        chk("random_settled_f", f4, ^pat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
